// File: rtl/ascon_input_sequencer.sv
// Packs a 32-bit little-endian AD/PT word stream into padded 128-bit Ascon blocks and paces them into the core.
// Optional macro ASCON_SEQ_ERR_EN adds a sticky err_o for bad byte counts and PT block overflow.
module ascon_input_sequencer #(
    parameter int MAX_PT_BLOCKS = 3,
    localparam int PW = $clog2(MAX_PT_BLOCKS + 1)
) (
    input  logic          clock_i,
    input  logic          resetb_i,
    input  logic          go_i,
    input  logic [31:0]   word_i,
    input  logic          word_valid_i,
    input  logic          word_last_i,
    input  logic [2:0]    word_bytes_i,
    output logic          word_ready_o,
    input  logic          end_init_i,
    input  logic          end_associate_i,
    input  logic          end_cipher_i,
    input  logic          end_i,
    output logic          start_o,
    output logic [127:0]  data_o,
    output logic          data_valid_o,
    output logic [PW-1:0] pt_bloc_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [3:0]    dbg_state_o
);
    // Handshake: a word transfers on a rising edge where word_valid_i and word_ready_o are both high;
    // word_ready_o depends only on the state register, never on word_valid_i.
    typedef enum logic [3:0] {
        S_IDLE, S_START, S_WAIT_INIT, S_FILL_AD, S_SEND_AD, S_WAIT_AD,
        S_FILL_PT, S_SEND_PT, S_WAIT_PT, S_WAIT_END
    } state_t;

    state_t         state_q, state_d;
    logic [127:0]   buf_q, buf_d;
    logic [127:0]   data_q, data_d;
    logic [1:0]     wcnt_q, wcnt_d;
    logic           last_q, last_d;
    logic           pad_q, pad_d;
    logic [PW-1:0]  pt_bloc_q, pt_bloc_d;
`ifdef ASCON_SEQ_ERR_EN
    logic           err_q, err_d;
    logic           bytes_bad;
    assign bytes_bad = word_last_i && (word_bytes_i == 3'd0 || word_bytes_i > 3'd4);
`endif

    logic [2:0]     nbytes;
    logic [31:0]    word_masked;
    logic [4:0]     fill_cnt;
    logic [127:0]   blk;
    logic           blk_done;
    logic           pt_full;

    assign nbytes   = (word_last_i && word_bytes_i != 3'd0 && word_bytes_i <= 3'd4) ? word_bytes_i : 3'd4;
    assign blk_done = (wcnt_q == 2'd3) || word_last_i;
    assign pt_full  = (pt_bloc_q == PW'(MAX_PT_BLOCKS));

    // Insert the current word and, on the last word, the 0x01 pad byte right after the valid bytes.
    always_comb begin
        word_masked = word_i;
        for (int k = 0; k < 4; k++) begin
            if (k >= int'(nbytes)) word_masked[8*k +: 8] = 8'h00;
        end
        fill_cnt = {1'b0, wcnt_q, 2'b00} + {2'b00, nbytes};
        blk = buf_q;
        blk[{wcnt_q, 5'b00000} +: 32] = word_masked;
        if (word_last_i && !fill_cnt[4]) blk[{fill_cnt[3:0], 3'b000} +: 8] = 8'h01;
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q   <= S_IDLE;
            buf_q     <= '0;
            data_q    <= '0;
            wcnt_q    <= '0;
            last_q    <= 1'b0;
            pad_q     <= 1'b0;
            pt_bloc_q <= '0;
`ifdef ASCON_SEQ_ERR_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            data_q    <= data_d;
            wcnt_q    <= wcnt_d;
            last_q    <= last_d;
            pad_q     <= pad_d;
            pt_bloc_q <= pt_bloc_d;
`ifdef ASCON_SEQ_ERR_EN
            err_q     <= err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        data_d    = data_q;
        wcnt_d    = wcnt_q;
        last_d    = last_q;
        pad_d     = pad_q;
        pt_bloc_d = pt_bloc_q;
`ifdef ASCON_SEQ_ERR_EN
        err_d     = err_q;
`endif
        case (state_q)
            S_IDLE: if (go_i) begin
                state_d   = S_START;
                buf_d     = '0;
                wcnt_d    = '0;
                last_d    = 1'b0;
                pad_d     = 1'b0;
                pt_bloc_d = '0;
`ifdef ASCON_SEQ_ERR_EN
                err_d     = 1'b0;
`endif
            end
            S_START:     state_d = S_WAIT_INIT;
            S_WAIT_INIT: if (end_init_i) state_d = S_FILL_AD;
            S_FILL_AD, S_FILL_PT: if (word_valid_i) begin
                if (blk_done) begin
                    data_d  = blk;
                    buf_d   = '0;
                    wcnt_d  = '0;
                    last_d  = word_last_i;
                    pad_d   = word_last_i && fill_cnt[4];
                    state_d = (state_q == S_FILL_AD) ? S_SEND_AD : S_SEND_PT;
                end else begin
                    buf_d  = blk;
                    wcnt_d = wcnt_q + 2'd1;
                end
`ifdef ASCON_SEQ_ERR_EN
                if (bytes_bad || (state_q == S_FILL_PT && blk_done && pt_full)) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
`endif
            end
            S_SEND_AD: state_d = S_WAIT_AD;
            S_SEND_PT: begin
                state_d = S_WAIT_PT;
                if (!pt_full) pt_bloc_d = pt_bloc_q + PW'(1);
            end
            S_WAIT_AD: if (end_associate_i) begin
                if (pad_q) begin
                    data_d  = 128'h1;
                    pad_d   = 1'b0;
                    state_d = S_SEND_AD;
                end else if (last_q) begin
                    last_d  = 1'b0;
                    state_d = S_FILL_PT;
                end else begin
                    state_d = S_FILL_AD;
                end
            end
            S_WAIT_PT: if (end_cipher_i) begin
                if (pad_q) begin
                    data_d  = 128'h1;
                    pad_d   = 1'b0;
                    state_d = S_SEND_PT;
`ifdef ASCON_SEQ_ERR_EN
                    if (pt_full) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end
`endif
                end else if (last_q) begin
                    last_d  = 1'b0;
                    state_d = S_WAIT_END;
                end else begin
                    state_d = S_FILL_PT;
                end
            end
            S_WAIT_END: if (end_i) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    assign start_o      = (state_q == S_START);
    assign word_ready_o = (state_q == S_FILL_AD) || (state_q == S_FILL_PT);
    assign data_valid_o = (state_q == S_SEND_AD) || (state_q == S_SEND_PT);
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = (state_q == S_WAIT_END) && end_i;
    assign data_o       = data_q;
    assign pt_bloc_o    = pt_bloc_q;
    assign dbg_state_o  = state_q;
`ifdef ASCON_SEQ_ERR_EN
    assign err_o        = err_q;
`else
    assign err_o        = 1'b0;
`endif

endmodule

// File: doc/ascon_input_sequencer.md
Name: ascon_input_sequencer

Overview:
- Upstream feeder for ascon_top2.
- Accepts associated data (AD) and plaintext (PT) as a 32-bit little-endian word stream with valid/ready/last, and packs them into 128-bit blocks with Ascon 0x01||0* padding.
- Drives start, data and data_valid into the cipher core and waits for its end_init/end_associate/end_cipher acknowledgements before sending the next block.

Parameters:
- MAX_PT_BLOCKS, 3, maximum PT blocks per message, padding block included; sets the width of pt_bloc_o as clog2(MAX_PT_BLOCKS+1).

Ports:
- clock_i  in  1  system clock, rising edge.
- resetb_i  in  1  asynchronous, active-low reset.
- go_i  in  1  one-cycle request to start a message; sampled only in IDLE.
- word_i  in  32  input word; byte k is in bits [8k+7:8k].
- word_valid_i  in  1  word_i is valid.
- word_last_i  in  1  last word of the current phase (AD, then PT).
- word_bytes_i  in  3  number of valid bytes, 1..4; honoured only with word_last_i, otherwise treated as 4.
- word_ready_o  out  1  sequencer can accept a word.
- end_init_i  in  1  core initialisation done, one-cycle pulse.
- end_associate_i  in  1  core finished absorbing an AD block.
- end_cipher_i  in  1  core finished a PT block.
- end_i  in  1  core tag ready.
- start_o  out  1  one-cycle start pulse to the core.
- data_o  out  128  packed block to the core.
- data_valid_o  out  1  one-cycle block-valid pulse.
- pt_bloc_o  out  clog2(MAX_PT_BLOCKS+1)  PT blocks sent so far in this message.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse when end_i is seen.
- err_o  out  1  sticky protocol error; only present with ASCON_SEQ_ERR_EN.

Behaviour:
- Reset values: all outputs 0 and state IDLE. Reset asserted mid-message aborts immediately; no pending block survives.
- State machine:
  - IDLE: on go_i, go to START.
  - START: start_o=1 for exactly one cycle, then WAIT_INIT.
  - WAIT_INIT: on end_init_i, go to FILL_AD.
  - FILL_AD / FILL_PT: word_ready_o=1.
    - Each accepted word (valid & ready) is written at byte offset 4*wcnt; wcnt is a 2-bit counter.
    - The block completes when wcnt wraps (16 bytes) or on word_last_i.
    - On completion, go to SEND_AD / SEND_PT. word_ready_o drops in the same cycle the completing word is accepted.
  - SEND_*: data_valid_o=1 for one cycle. data_o is updated the same cycle and held until the next SEND.
    - Then WAIT_AD / WAIT_PT.
    - pt_bloc_o increments in SEND_PT.
  - WAIT_AD: on end_associate_i:
    - padding pending: go to SEND_AD with the pad block;
    - last seen: go to FILL_PT;
    - otherwise: go to FILL_AD.
  - WAIT_PT: on end_cipher_i, same rule as WAIT_AD, except that after the last PT block it goes to WAIT_END.
  - WAIT_END: on end_i, done_o=1 for one cycle, go to IDLE, and clear pt_bloc_o on entry to START of the next message.
- Padding: with n valid bytes in the final block (n<16), byte n = 0x01 and bytes n+1..15 = 0.
  - If the last word exactly fills byte 15 (n=16), set pad_pending. The next block sent is 128'h1 (0x01 at bits[7:0]).
- Bytes beyond word_bytes_i on the last word are masked to 0 before the pad byte is inserted.
- Handshake pulses (end_*) that arrive in a state not waiting for them are ignored.
- end_i arriving before WAIT_END is ignored.
- go_i outside IDLE is ignored.
- word_valid_i outside FILL_* is ignored; the word is not consumed.
- Block latency: SEND follows the completing word's acceptance by 1 cycle.

Optional Feature:
- Macro: ASCON_SEQ_ERR_EN.
- When defined, err_o is set and the FSM returns to IDLE if any of these occurs:
  - word_last_i with word_bytes_i==0 or >4;
  - a PT block would make pt_bloc_o exceed MAX_PT_BLOCKS.
- err_o clears only on reset or on the next go_i.
- When not defined, err_o is tied to 0 and neither check is performed. Out-of-range word_bytes_i is then treated as 4, and pt_bloc_o saturates.

Test Plan:
- Reset check: hold resetb_i=0 for 2 cycles -> all outputs 0; after release, busy_o=0.
- Start handshake: go_i pulse -> start_o high exactly one cycle later for one cycle. Pulse end_init_i 5 cycles later -> word_ready_o=1 on the next cycle.
- AD block, "Alice to Bob": feed words 0x63696C41, 0x6F742065, 0x626F4220 (last, bytes=4) -> one data_valid_o pulse with data_o=0x00000001626F42206F74206563696C41. word_ready_o stays 0 until end_associate_i.
- Plaintext, 3 blocks: send 16 bytes, then 16 bytes, then 15 bytes (last word bytes=3), acking each block with end_cipher_i.
  - Expected blocks: 0x704F2065726964207475657620657551, 0x766E49206561727574614E2061747265, then a third block with bits[127:120]=0x01.
  - pt_bloc_o steps 1, 2, 3. end_i -> done_o pulse, then IDLE.
- Full-block boundary: PT of exactly 32 bytes -> third block equals 128'h1 and is sent after end_cipher_i of block 2.
- Abort and error:
  - Assert resetb_i=0 in WAIT_PT -> outputs go to 0 immediately.
  - With ASCON_SEQ_ERR_EN defined, a 4th PT block and MAX_PT_BLOCKS=3 -> err_o=1 and busy_o=0.
